// File: rtl/miniRV_pkg.sv
// Shared constants and types for the miniRV load/store unit.
package miniRV_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge channel between the MEM stage and memory.
interface mem_access_if;
  import miniRV_pkg::*;

  logic              dbus_req;
  logic              dbus_we;
  logic [31:0]       dbus_addr;
  logic [DATA_W-1:0] dbus_wdata;
  logic [3:0]        dbus_wstrb;
  logic              dbus_ack;
  logic [DATA_W-1:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    output dbus_ack, dbus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: legality check, store byte enables/replication,
// and load byte/halfword extraction with sign or zero extension.
module lsu_align
  import miniRV_pkg::*;
(
  input  logic              valid,
  input  logic              re,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] st_data,
  output logic              legal,
  output logic              illegal,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data
);

  function automatic logic [DATA_W-1:0] ext8(input logic signed [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic signed [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
  endfunction

  logic f3_ok;
  logic aligned;

  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b0;
    if (we) f3_ok = funct3 inside {F3_B, F3_H, F3_W};
    else    f3_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    case (funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~off[0];
      default: aligned = (off == 2'd0);
    endcase
    legal   = valid & (re ^ we) & f3_ok & aligned;
    // A valid slot with neither re nor we is a non-memory instruction, not a fault.
    illegal = valid & (re | we) & ~legal;
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    case (funct3[1:0])
      2'd0: begin
        wstrb = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      2'd1: begin
        wstrb = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      2'd2: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = '0;
      end
    endcase
  end

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[8*ld_off +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    case (ld_funct3)
      F3_B:    ld_data = ext8(ld_byte, 1'b1);
      F3_BU:   ld_data = ext8(ld_byte, 1'b0);
      F3_H:    ld_data = ext16(ld_half, 1'b1);
      F3_HU:   ld_data = ext16(ld_half, 1'b0);
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-bus sequencer: IDLE -> BUSY (held request, watchdog) -> DONE,
// stalling the pipeline until the bus completes or the watchdog fires.
module mem_access
  import miniRV_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_ram_re,
  input  logic              mem_ram_we,
  input  logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_ALU_C,
  input  logic [DATA_W-1:0] mem_rD2,
  mem_access_if.master      dbus,
  output logic [DATA_W-1:0] mem_DRAM_rdo,
  output logic              mem_stall,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic [7:0]        wd_q, wd_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] rdo_q;
  logic              err_q, err_d;

  logic              legal, illegal;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic              latch, capture, timeout, stall;

  lsu_align u_align (
    .valid     (mem_valid),
    .re        (mem_ram_re),
    .we        (mem_ram_we),
    .funct3    (mem_funct3),
    .off       (mem_ALU_C[1:0]),
    .st_data   (mem_rD2),
    .legal     (legal),
    .illegal   (illegal),
    .wstrb     (st_wstrb),
    .wdata     (st_wdata),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (dbus.dbus_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    latch   = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    err_d   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = BUSY;
          wd_d    = 8'd0;
          latch   = 1'b1;
          stall   = 1'b1;
        end else if (illegal) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dbus.dbus_ack) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
          if (wd_q == MEM_TIMEOUT - 8'd1) begin
            state_d = DONE;
            timeout = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      rdo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      if (latch) begin
        we_q    <= mem_ram_we;
        addr_q  <= {mem_ALU_C[31:2], 2'b00};
        wdata_q <= st_wdata;
        wstrb_q <= mem_ram_we ? st_wstrb : 4'b0000;
      end
      if (capture && !we_q)      rdo_q <= ld_data;
      else if (timeout && !we_q) rdo_q <= '0;
    end
  end

  // Load-format selectors only matter once BUSY begins, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      off_q <= mem_ALU_C[1:0];
      f3_q  <= mem_funct3;
    end
  end

  assign dbus.dbus_req   = (state_q == BUSY);
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_wdata = wdata_q;
  assign dbus.dbus_wstrb = wstrb_q;
  assign mem_DRAM_rdo    = rdo_q;
  assign mem_err         = err_q;
  assign mem_stall       = stall & ~rst;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed corner cases plus randomized
// accesses compared against an arithmetic model of the load/store rules.
module tb_mem_access;
  import miniRV_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ram_re, mem_ram_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_ALU_C, mem_rD2;
  logic [31:0] mem_DRAM_rdo;
  logic        mem_stall, mem_err;

  mem_access_if bus ();

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_ram_re   (mem_ram_re),
    .mem_ram_we   (mem_ram_we),
    .mem_funct3   (mem_funct3),
    .mem_ALU_C    (mem_ALU_C),
    .mem_rD2      (mem_rD2),
    .dbus         (bus),
    .mem_DRAM_rdo (mem_DRAM_rdo),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdo  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid    = 1'b0;
    mem_ram_re   = 1'b0;
    mem_ram_we   = 1'b0;
    bus.dbus_ack = 1'b0;
  endtask

  // Reference rules, expressed arithmetically.
  function automatic bit m_legal(input logic v, re, we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    if (!v || (re == we)) return 1'b0;
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (re && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    sz = 32'd1 << (f3 % 3'd4);
    return (a % sz) == 32'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] s, b, h;
    s = rd >> (8 * off);
    b = s & 32'hFF;
    h = s & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] m_strb(input logic [2:0] f3, input int off);
    case (f3)
      3'd0:    return 32'd1 << off;
      3'd1:    return (off >= 2) ? 32'd12 : 32'd3;
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
      3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // One MEM-stage slot, presented in IDLE. ack_dly < 0 means the bus never answers.
  task automatic run_access(input logic v, re, we, input logic [2:0] f3,
                            input logic [31:0] a, wd, rd, input int ack_dly, input logic stray);
    bit lg, il, acked;
    int busy, stalls, off;
    lg  = m_legal(v, re, we, f3, a);
    il  = v && (re || we) && !lg;
    off = int'(a % 32'd4);
    mem_valid = v; mem_ram_re = re; mem_ram_we = we; mem_funct3 = f3;
    mem_ALU_C = a; mem_rD2 = wd; bus.dbus_rdata = rd; bus.dbus_ack = 1'b0;
    #1;
    if (lg) begin
      chk1("idle_stall", mem_stall, 1'b1);
      stalls = 1; busy = 0; acked = 0;
      for (int k = 0; k < 300; k++) begin
        step();
        bus.dbus_ack = (k == ack_dly);
        #1;
        busy++;
        if (mem_stall) stalls++;
        chk1("busy_req", bus.dbus_req, 1'b1);
        chk("busy_addr", bus.dbus_addr, a & 32'hFFFF_FFFC);
        chk1("busy_we", bus.dbus_we, we);
        if (we) begin
          chk("busy_wstrb", {28'd0, bus.dbus_wstrb}, m_strb(f3, off));
          chk("busy_wdata", bus.dbus_wdata, m_wdata(f3, wd));
        end
        if (k == ack_dly) begin acked = 1; break; end
        if (busy == 255) break;
      end
      step();
      bus.dbus_ack = stray;
      #1;
      if (re) exp_rdo = acked ? m_load(f3, off, rd) : 32'd0;
      chk1("done_req", bus.dbus_req, 1'b0);
      chk1("done_stall", mem_stall, 1'b0);
      chk("done_rdo", mem_DRAM_rdo, exp_rdo);
      chk1("done_err", mem_err, !acked);
      chk("stall_cycles", stalls, acked ? ack_dly + 2 : 256);
      step();
      idle_inputs();
      #1;
      chk("back_idle", 32'(dut.state_q), 32'(IDLE));
      chk1("idle_err", mem_err, 1'b0);
      chk1("idle_req", bus.dbus_req, 1'b0);
    end else begin
      chk1("nolegal_stall", mem_stall, 1'b0);
      chk1("nolegal_req", bus.dbus_req, 1'b0);
      step();
      idle_inputs();
      #1;
      chk1("err_pulse", mem_err, il);
      chk1("after_req", bus.dbus_req, 1'b0);
      chk1("after_stall", mem_stall, 1'b0);
      chk("after_rdo", mem_DRAM_rdo, exp_rdo);
      step();
      #1;
      chk1("err_clear", mem_err, 1'b0);
    end
  endtask

  initial begin
    int sel;
    logic re, we;

    // Reset with a legal access presented: nothing may start or stall.
    rst = 1'b1;
    idle_inputs();
    bus.dbus_rdata = 32'd0;
    mem_valid = 1'b1; mem_ram_re = 1'b1; mem_funct3 = F3_W;
    mem_ALU_C = 32'h40; mem_rD2 = 32'h5555_AAAA;
    step();
    step();
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_req", bus.dbus_req, 1'b0);
    chk1("rst_we", bus.dbus_we, 1'b0);
    chk("rst_addr", bus.dbus_addr, 32'd0);
    chk("rst_wdata", bus.dbus_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, bus.dbus_wstrb}, 32'd0);
    chk("rst_rdo", mem_DRAM_rdo, 32'd0);
    chk1("rst_err", mem_err, 1'b0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    idle_inputs();
    rst = 1'b0;
    step();

    run_access(1, 1, 0, F3_B,  32'h103, 32'd0,       32'h80FF_FF12, 0, 0);
    chk("lb_rdo", mem_DRAM_rdo, 32'hFFFF_FF80);
    run_access(1, 0, 1, F3_H,  32'h102, 32'h0000_ABCD, 32'hDEAD_BEEF, 0, 1);
    chk("sh_rdo_hold", mem_DRAM_rdo, 32'hFFFF_FF80);
    run_access(1, 1, 0, F3_W,  32'h101, 32'd0,       32'h1234_5678, 0, 0);
    run_access(1, 1, 0, F3_HU, 32'h002, 32'd0,       32'h8001_0000, 4, 0);
    chk("lhu_rdo", mem_DRAM_rdo, 32'h0000_8001);
    run_access(1, 1, 0, F3_W,  32'h200, 32'd0,       32'hFFFF_FFFF, -1, 0);
    chk("timeout_rdo", mem_DRAM_rdo, 32'd0);
    run_access(1, 1, 0, F3_W,  32'h010, 32'd0,       32'h1234_5678, 1, 1);
    run_access(1, 1, 1, F3_W,  32'h020, 32'h1,       32'h0, 0, 0);
    run_access(1, 0, 1, F3_BU, 32'h021, 32'h1,       32'h0, 0, 0);
    run_access(1, 0, 1, F3_H,  32'h023, 32'h1,       32'h0, 0, 0);
    run_access(0, 1, 1, F3_W,  32'h101, 32'h1,       32'h0, 0, 0);
    run_access(1, 0, 1, F3_B,  32'h331, 32'h0000_00C3, 32'h0, 2, 0);
    run_access(1, 1, 0, F3_H,  32'h336, 32'd0,       32'h8421_7FFF, 3, 1);

    // Reset while BUSY, followed by a late ack that must be ignored.
    mem_valid = 1'b1; mem_ram_re = 1'b1; mem_ram_we = 1'b0; mem_funct3 = F3_W;
    mem_ALU_C = 32'h80; bus.dbus_rdata = 32'hCAFE_F00D; bus.dbus_ack = 1'b0;
    step();
    chk1("rb_busy_req", bus.dbus_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rb_rst_stall", mem_stall, 1'b0);
    step();
    rst = 1'b0;
    idle_inputs();
    bus.dbus_ack = 1'b1;
    #1;
    exp_rdo = 32'd0;
    chk1("rb_req_drop", bus.dbus_req, 1'b0);
    chk("rb_state", 32'(dut.state_q), 32'(IDLE));
    chk("rb_rdo", mem_DRAM_rdo, 32'd0);
    chk1("rb_err", mem_err, 1'b0);
    step();
    bus.dbus_ack = 1'b0;
    #1;
    chk1("rb_stray_req", bus.dbus_req, 1'b0);
    chk1("rb_stray_err", mem_err, 1'b0);
    chk("rb_stray_rdo", mem_DRAM_rdo, 32'd0);
    chk("rb_stray_state", 32'(dut.state_q), 32'(IDLE));

    // Randomized slots against the reference rules.
    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 10);
      re  = (sel < 5) || (sel == 9);
      we  = (sel >= 5) && (sel <= 9);
      run_access(($urandom % 6) != 0, re, we, 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, $urandom_range(0, 4), 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 mem_valid  in  1  MEM-stage instruction valid.
REQ-005 mem_ram_re  in  1  load request.
REQ-006 mem_ram_we  in  1  store request.
REQ-007 mem_funct3  in  3  access size/sign: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; stores use 0 sb, 1 sh, 2 sw.
REQ-008 mem_ALU_C  in  32  byte address.
REQ-009 mem_rD2  in  32  store data.
REQ-010 dbus_req  out  1  bus request, held until ack.
REQ-011 dbus_we  out  1  write request.
REQ-012 dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 dbus_wdata  out  32  lane-replicated store data.
REQ-014 dbus_wstrb  out  4  byte enables.
REQ-015 dbus_ack  in  1  single-cycle completion.
REQ-016 dbus_rdata  in  32  read word, valid with ack.
REQ-017 mem_DRAM_rdo  out  32  formatted load result, feeds the MEM/WB register.
REQ-018 mem_stall  out  1  freeze IF..EX/MEM.
REQ-019 mem_err  out  1  one-cycle pulse: misaligned, illegal, or timed-out access.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-021 An access is "legal" when mem_valid=1, exactly one of re/we is set, the funct3 is supported for that type, and the address is aligned (h: addr[0]=0; w: addr[1:0]=0).
REQ-022 In IDLE with a legal access, the block SHALL latch addr, wdata, wstrb, we, and funct3, go to BUSY, and assert mem_stall combinationally in that cycle.
REQ-023 In BUSY, dbus_req SHALL be 1 with the latched fields stable, and mem_stall SHALL be 1.
REQ-024 In BUSY with dbus_ack=1, the block SHALL go to DONE; for a load, it SHALL register the formatted dbus_rdata into mem_DRAM_rdo on that edge.
REQ-025 In DONE, dbus_req=0 and mem_stall=0, so the pipeline advances; DONE SHALL always go to IDLE and never starts an access.
REQ-026 Minimum latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE), and mem_DRAM_rdo SHALL be valid in DONE.
REQ-027 Load formatting: the byte or halfword SHALL be selected by addr[1:0]; lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
REQ-028 Store lanes:
- sb: wstrb=1<<addr[1:0], byte replicated ×4.
- sh: wstrb=0011 when addr[1]=0, else 1100; halfword replicated ×2.
- sw: wstrb=1111.
REQ-029 In IDLE, an illegal access (mem_valid=1 with misalignment, re&we both set, or unsupported funct3) SHALL:
- pulse mem_err for one cycle;
- issue no bus request and no stall;
- leave mem_DRAM_rdo unchanged.
REQ-030 Watchdog: an 8-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without ack.
REQ-031 When the watchdog reaches 255, the block SHALL go to DONE, pulse mem_err, and set mem_DRAM_rdo=0 for a load.
REQ-032 dbus_ack in IDLE or DONE SHALL be ignored.
REQ-033 mem_DRAM_rdo SHALL hold its value between loads; stores SHALL not modify it.
REQ-034 An input with mem_valid=0 SHALL cause no action regardless of re/we.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL set:
- state=IDLE, watchdog=0;
- dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_wstrb=0;
- mem_DRAM_rdo=0, mem_err=0.
REQ-036 mem_stall SHALL be 0 while rst=1.
REQ-037 Reset asserted in BUSY SHALL drop dbus_req from the next edge; a later stray ack SHALL be ignored.

Structure
REQ-038 The shared package miniRV_pkg SHALL hold: the funct3 size constants, the state enum {IDLE, BUSY, DONE}, and MEM_TIMEOUT=255.
REQ-039 The sub-module lsu_align SHALL be combinational and contain:
- wstrb and wdata generation;
- load extraction and extension;
- the legality check.
mem_access SHALL instantiate it once.

Verification
REQ-040 Bench SHALL cover: lb, addr=0x103, rdata=0x80FF_FF12 -> rdo=0xFFFF_FF80 in DONE; stall high for 2 cycles.
REQ-041 Bench SHALL cover: sh, addr=0x102, rD2=0x0000_ABCD -> wstrb=1100, wdata=0xABCD_ABCD, dbus_addr=0x100, rdo unchanged.
REQ-042 Bench SHALL cover: lw, addr=0x101 -> mem_err pulse, dbus_req=0 and stall=0 throughout.
REQ-043 Bench SHALL cover: lhu, addr=0x2, ack delayed 5 cycles, rdata=0x8001_0000 -> rdo=0x0000_8001; stall=1 for 6 cycles.
REQ-044 Bench SHALL cover: lw with ack never asserted -> mem_err after 255 BUSY cycles, rdo=0, FSM returns to IDLE.
REQ-045 Bench SHALL cover: rst in BUSY, then ack one cycle later -> dbus_req=0, state IDLE, rdo=0, no mem_err.
